// File: rtl/ir_cmd_controller_if.sv
// +--------------------------------------------------------------------------+
// | ir_cmd_controller_if : key input strobe and camera-control outputs       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ir_cmd_controller_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic [2:0] filter_mode;
  logic [7:0] brightness;
  logic       freeze;
  logic       capture_pulse;
  logic       cmd_strobe;
  logic       unknown_key;
  logic       busy;

  modport master (
    output key_code, key_valid,
    input  filter_mode, brightness, freeze, capture_pulse, cmd_strobe, unknown_key, busy
  );

  modport slave (
    input  key_code, key_valid,
    output filter_mode, brightness, freeze, capture_pulse, cmd_strobe, unknown_key, busy
  );
endinterface

`default_nettype wire

// File: rtl/ir_cmd_controller.sv
// +--------------------------------------------------------------------------+
// | ir_cmd_controller : IR key -> camera control with same-key hold-off      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ir_cmd_controller #(
  parameter int         HOLDOFF_CYCLES = 12_500_000,
  parameter int         NUM_MODES      = 5,
  parameter int         BRIGHT_STEP    = 8,
  parameter logic [7:0] KEY_MODE_NEXT  = 8'h1A,
  parameter logic [7:0] KEY_MODE_PREV  = 8'h1B,
  parameter logic [7:0] KEY_BRIGHT_UP  = 8'h1C,
  parameter logic [7:0] KEY_BRIGHT_DN  = 8'h1D,
  parameter logic [7:0] KEY_FREEZE     = 8'h1E,
  parameter logic [7:0] KEY_CAPTURE    = 8'h1F,
  parameter logic [7:0] KEY_RESET      = 8'h12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ir_cmd_controller_if.slave   bus
);

  localparam int         CNT_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [2:0] MODE_MAX = 3'(NUM_MODES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    APPLY   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       cur_code, cur_code_nxt;
  logic [7:0]       last_code, last_code_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mode, mode_nxt;
  logic [7:0]       bright, bright_nxt;
  logic             frz, frz_nxt;
  logic             cap, cap_nxt;
  logic             cmd, cmd_nxt;
  logic             unk, unk_nxt;

  logic signed [8:0] up_sum;
  logic signed [8:0] dn_sum;

  // Sums are formed one bit wider so saturation can be decided without wrap.
  assign up_sum = $signed({bright[7], bright}) + $signed(9'(BRIGHT_STEP));
  assign dn_sum = $signed({bright[7], bright}) - $signed(9'(BRIGHT_STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_code  <= 8'h00;
      last_code <= 8'h00;
      cnt       <= '0;
      mode      <= 3'd0;
      bright    <= 8'h00;
      frz       <= 1'b0;
      cap       <= 1'b0;
      cmd       <= 1'b0;
      unk       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_code  <= cur_code_nxt;
      last_code <= last_code_nxt;
      cnt       <= cnt_nxt;
      mode      <= mode_nxt;
      bright    <= bright_nxt;
      frz       <= frz_nxt;
      cap       <= cap_nxt;
      cmd       <= cmd_nxt;
      unk       <= unk_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_code_nxt  = cur_code;
    last_code_nxt = last_code;
    cnt_nxt       = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    mode_nxt      = mode;
    bright_nxt    = bright;
    frz_nxt       = frz;
    cap_nxt       = 1'b0;
    cmd_nxt       = 1'b0;
    unk_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.key_valid) begin
          cur_code_nxt = bus.key_code;
          state_nxt    = DECODE;
        end
      end

      DECODE: begin
        // Window only blocks a repeat of the same key; the counter is not reloaded.
        if ((cnt != '0) && (cur_code == last_code)) state_nxt = HOLDOFF;
        else                                        state_nxt = APPLY;
      end

      APPLY: begin
        last_code_nxt = cur_code;
        cnt_nxt       = CNT_LOAD;
        state_nxt     = HOLDOFF;
        cmd_nxt       = 1'b1;
        if (cur_code == KEY_MODE_NEXT) begin
          mode_nxt = (mode == MODE_MAX) ? 3'd0 : mode + 3'd1;
        end else if (cur_code == KEY_MODE_PREV) begin
          mode_nxt = (mode == 3'd0) ? MODE_MAX : mode - 3'd1;
        end else if (cur_code == KEY_BRIGHT_UP) begin
          bright_nxt = (up_sum > 9'sd127) ? 8'h7F : up_sum[7:0];
        end else if (cur_code == KEY_BRIGHT_DN) begin
          bright_nxt = (dn_sum < -9'sd128) ? 8'h80 : dn_sum[7:0];
        end else if (cur_code == KEY_FREEZE) begin
          frz_nxt = ~frz;
        end else if (cur_code == KEY_CAPTURE) begin
          cap_nxt = 1'b1;
        end else if (cur_code == KEY_RESET) begin
          mode_nxt   = 3'd0;
          bright_nxt = 8'h00;
          frz_nxt    = 1'b0;
        end else begin
          cmd_nxt = 1'b0;
          unk_nxt = 1'b1;
        end
      end

      HOLDOFF: begin
        if (bus.key_valid) begin
          cur_code_nxt = bus.key_code;
          state_nxt    = DECODE;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.filter_mode   = mode;
  assign bus.brightness    = bright;
  assign bus.freeze        = frz;
  assign bus.capture_pulse = cap;
  assign bus.cmd_strobe    = cmd;
  assign bus.unknown_key   = unk;
  assign bus.busy          = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ir_cmd_controller.sv
// +--------------------------------------------------------------------------+
// | tb_ir_cmd_controller : directed self-checking bench for ir_cmd_controller|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ir_cmd_controller;

  localparam int HOLD = 50;   // scaled-down hold-off window
  localparam int GAP  = 60;   // idle cycles that exceed the window

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ir_cmd_controller_if bus ();

  ir_cmd_controller #(.HOLDOFF_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One key strobe; checks strobe timing at k+1, k+2 and k+3.
  task automatic press(input logic [7:0] code, input logic ecmd, input logic eunk,
                       input logic ecap);
    @(negedge clk);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    check("busy_k", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("cmd_k1", 32'(bus.cmd_strobe), 32'd0);
    @(posedge clk); #1;
    check("cmd_k2", 32'(bus.cmd_strobe), 32'(ecmd));
    check("unk_k2", 32'(bus.unknown_key), 32'(eunk));
    check("cap_k2", 32'(bus.capture_pulse), 32'(ecap));
    @(posedge clk); #1;
    check("strobes_k3", {29'd0, bus.cmd_strobe, bus.unknown_key, bus.capture_pulse}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1 ^ rst_n ^ rst_n ^ 1'b1;  // stays low
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  int exp_b;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.key_code  = 8'h00;
    bus.key_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode",   32'(bus.filter_mode), 32'd0);
    check("rst_bright", 32'(bus.brightness), 32'd0);
    check("rst_freeze", 32'(bus.freeze), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_strobe", {29'd0, bus.cmd_strobe, bus.unknown_key, bus.capture_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);

    // NEXT x5 wraps 4 -> 0
    press(8'h1A, 1, 0, 0); check("next1", 32'(bus.filter_mode), 32'd1); gap(GAP);
    press(8'h1A, 1, 0, 0); check("next2", 32'(bus.filter_mode), 32'd2); gap(GAP);
    press(8'h1A, 1, 0, 0); check("next3", 32'(bus.filter_mode), 32'd3); gap(GAP);
    press(8'h1A, 1, 0, 0); check("next4", 32'(bus.filter_mode), 32'd4); gap(GAP);
    press(8'h1A, 1, 0, 0); check("next5", 32'(bus.filter_mode), 32'd0); gap(GAP);

    // PREV from reset wraps 0 -> 4
    do_reset();
    press(8'h1B, 1, 0, 0); check("prev_wrap", 32'(bus.filter_mode), 32'd4); gap(GAP);

    // Same key inside the window is dropped
    press(8'h1C, 1, 0, 0); check("bup_first", 32'(bus.brightness), 32'd8);
    gap(10);
    press(8'h1C, 0, 0, 0); check("bup_dropped", 32'(bus.brightness), 32'd8);
    gap(GAP);
    press(8'h1C, 1, 0, 0); check("bup_third", 32'(bus.brightness), 32'd16);
    gap(GAP);

    // Saturation both ways
    exp_b = 16;
    for (int i = 0; i < 20; i++) begin
      press(8'h1C, 1, 0, 0);
      exp_b = (exp_b + 8 > 127) ? 127 : exp_b + 8;
      check("bup_sat", 32'(bus.brightness), 32'(exp_b[7:0]));
      gap(GAP);
    end
    check("bright_max", 32'(bus.brightness), 32'h7F);
    for (int i = 0; i < 40; i++) begin
      press(8'h1D, 1, 0, 0);
      exp_b = (exp_b - 8 < -128) ? -128 : exp_b - 8;
      check("bdn_sat", 32'(bus.brightness), 32'(exp_b[7:0]));
      gap(GAP);
    end
    check("bright_min", 32'(bus.brightness), 32'h80);

    // Different key accepted inside the window
    press(8'h1A, 1, 0, 0); check("next_wrap2", 32'(bus.filter_mode), 32'd0);
    gap(2);
    press(8'h1F, 1, 0, 1); check("cap_mode", 32'(bus.filter_mode), 32'd0);
    gap(GAP);
    press(8'h1E, 1, 0, 0); check("freeze_on", 32'(bus.freeze), 32'd1); gap(GAP);
    press(8'h1F, 1, 0, 1); check("cap_frozen", 32'(bus.freeze), 32'd1); gap(GAP);
    press(8'h1E, 1, 0, 0); check("freeze_off", 32'(bus.freeze), 32'd0); gap(GAP);

    // Unmapped key
    press(8'h55, 0, 1, 0);
    check("unk_mode",   32'(bus.filter_mode), 32'd0);
    check("unk_bright", 32'(bus.brightness), 32'h80);
    check("unk_freeze", 32'(bus.freeze), 32'd0);
    gap(GAP);

    // RESET key
    press(8'h1E, 1, 0, 0); gap(2);
    press(8'h1A, 1, 0, 0); gap(2);
    press(8'h12, 1, 0, 0);
    check("rkey_mode",   32'(bus.filter_mode), 32'd0);
    check("rkey_bright", 32'(bus.brightness), 32'd0);
    check("rkey_freeze", 32'(bus.freeze), 32'd0);
    gap(GAP);

    // Async reset while in HOLDOFF
    press(8'h1C, 1, 0, 0); check("pre_rst_bright", 32'(bus.brightness), 32'd8);
    press(8'h1A, 1, 0, 0); check("pre_rst_mode", 32'(bus.filter_mode), 32'd1);
    gap(3);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(bus.busy), 32'd0);
    check("arst_mode",   32'(bus.filter_mode), 32'd0);
    check("arst_bright", 32'(bus.brightness), 32'd0);
    check("arst_strobe", {29'd0, bus.cmd_strobe, bus.unknown_key, bus.capture_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    gap(3);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
